// File: rtl/signed_mac_pkg.sv
// signed_mac_pkg
// Shared definitions for the signed multiply-accumulate slice:
//   - state_t      : control states ACCUM / DRAIN / HOLD
//   - DEF_*        : default operand, accumulator and run-length parameters
//   - sat_max/min  : two's-complement limits for an arbitrary width (<= 64)
package signed_mac_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_LEN   = 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Largest positive value representable in 'width' signed bits.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in 'width' signed bits.
  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/signed_mac_acc_mul.sv
// signed_mul_stage
// Registered W x W signed multiplier with a valid bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, drops p_valid (and p) this edge
//   en         : operand pair accepted this cycle
//   a, b       : signed operands (two's complement, W bits)
//   p          : registered 2W-bit signed product
//   p_valid    : p holds a product that has not yet been accumulated
module signed_mul_stage #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p,
  output logic           p_valid
);

  // Sign-extend to full product width so the multiply is exact.
  logic signed [2*W-1:0] a_x, b_x;
  assign a_x = (2*W)'($signed(a));
  assign b_x = (2*W)'($signed(b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p       <= '0;
      p_valid <= 1'b0;
    end else if (clr) begin
      p       <= '0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= en;
      if (en) p <= a_x * b_x;
    end
  end

endmodule

// File: rtl/signed_mac_acc.sv
// signed_mac_acc
// Registered signed multiply-accumulate: LEN operand pairs are multiplied
// (one registered stage) and summed into an ACC_W-bit accumulator; the
// dot product is then offered on a valid/ready port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous abort, highest priority, drops any result
//   a, b, in_valid      : signed operand pair and its valid
//   in_ready            : pair accepted when in_valid && in_ready
//   acc_out, out_valid  : accumulated result and its valid
//   out_ready           : downstream takes the result
//   ovf                 : sticky overflow flag for the current result
// Compile option: SIGNED_MAC_SAT_EN defined -> saturating accumulate with
// sticky ovf; undefined -> wrap modulo 2^ACC_W, ovf tied low.
module signed_mac_acc
  import signed_mac_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN   = DEF_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int               CNT_W    = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [2*W-1:0]   p;
  logic             p_valid;
  logic             accept;
  logic             res_take;

  // in_ready is gated by rst_n so every output reads 0 while reset is held.
  assign in_ready = rst_n && !clr && (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign res_take = out_valid && out_ready;
  assign acc_out  = acc;

  signed_mul_stage #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .en      (accept),
    .a       (a),
    .b       (b),
    .p       (p),
    .p_valid (p_valid)
  );

  // Control: cnt counts accepts; DRAIN waits for the final product to be
  // folded into acc (p_valid low) before presenting the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= ACCUM;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!p_valid) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            cnt       <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          cnt       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // One guard bit above the accumulator: overflow shows up as the top two
  // bits of the sum disagreeing.
  logic signed [ACC_W:0] sum;
  logic [ACC_W-1:0]      acc_nxt;
  assign sum = (ACC_W+1)'($signed(acc)) + (ACC_W+1)'($signed(p));

`ifdef SIGNED_MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  logic ovf_evt;
  logic ovf_q;
  assign ovf_evt = sum[ACC_W] ^ sum[ACC_W-1];
  // Guard bit carries the true sign: set -> clamp low, clear -> clamp high.
  assign acc_nxt = ovf_evt ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
  assign ovf     = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ovf_q <= 1'b0;
    else if (clr || res_take)   ovf_q <= 1'b0;
    else if (p_valid && ovf_evt) ovf_q <= 1'b1;
  end
`else
  // Wrap build: the guard bit plays no part in the result.
  logic unused_sum_msb;
  assign unused_sum_msb = sum[ACC_W];
  assign acc_nxt        = sum[ACC_W-1:0];
  assign ovf            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               acc <= '0;
    else if (clr || res_take) acc <= '0;
    else if (p_valid)         acc <= acc_nxt;
  end

endmodule

// File: tb/tb_signed_mac_acc.sv
module tb_signed_mac_acc;

  localparam int W   = 8;
  localparam int AW  = 16;
  localparam int LEN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] acc_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          ovf;

  // LEN=1 instance
  logic [W-1:0]  a1 = '0, b1 = '0;
  logic          in_valid1 = 1'b0;
  logic          in_ready1;
  logic [AW-1:0] acc_out1;
  logic          out_valid1;
  logic          out_ready1 = 1'b1;
  logic          ovf1;

  always #5 clk = ~clk;

  signed_mac_acc #(.W(W), .ACC_W(AW), .LEN(LEN)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  signed_mac_acc #(.W(W), .ACC_W(AW), .LEN(1)) u_len1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .a(a1), .b(b1),
    .in_valid(in_valid1), .in_ready(in_ready1), .acc_out(acc_out1),
    .out_valid(out_valid1), .out_ready(out_ready1), .ovf(ovf1)
  );

  typedef struct {
    int   acc;
    logic ovf;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef SIGNED_MAC_SAT_EN
  localparam int   POS_EXP = 32767;
  localparam int   NEG_EXP = -32768;
  localparam logic OVF_EXP = 1'b1;
`else
  localparam int   POS_EXP = -1020;
  localparam int   NEG_EXP = 512;
  localparam logic OVF_EXP = 1'b0;
`endif

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input int acc_v, input logic ovf_v);
    exp_t e;
    e.acc = acc_v;
    e.ovf = ovf_v;
    q.push_back(e);
  endtask

  // Scoreboard monitor: every result handshake is compared against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %0d expected none", $signed(acc_out));
      end else begin
        e = q.pop_front();
        chk("result_acc", $signed(acc_out), e.acc);
        chk("result_ovf", ovf, e.ovf);
      end
    end
  end

  // Present one pair and return just after the edge that accepts it.
  task automatic send(input int av, input int bv);
    int t;
    a = 8'(av);
    b = 8'(bv);
    in_valid = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 50) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && q.size() != 0; t++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state
    #1 rst_n = 1'b0;
    #10;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", $signed(acc_out), 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Basic dot product and result latency
    out_ready = 1'b1;
    push(16455, 1'b0);
    send(3, -5); send(10, 10); send(-7, 2); send(-128, -128);
    @(negedge clk); chk("lat_edge_k1", out_valid, 0);
    @(negedge clk); chk("lat_edge_k2", out_valid, 0);
    @(negedge clk); chk("lat_edge_k3", out_valid, 1);
    drain();

    // Backpressure: result held stable, no new accepts
    out_ready = 1'b0;
    push(16455, 1'b0);
    send(3, -5); send(10, 10); send(-7, 2); send(-128, -128);
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_acc_stable", $signed(acc_out), 16455);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_take", in_ready, 1);
    chk("acc_restart", $signed(acc_out), 0);

    // Overflow: saturate or wrap depending on build
    push(POS_EXP, OVF_EXP);
    repeat (4) send(127, 127);
    drain();
    push(NEG_EXP, OVF_EXP);
    repeat (4) send(-128, 127);
    drain();
    chk("ovf_cleared", ovf, 0);

    // clr after two accepts, then gapped pairs
    send(3, 4); send(3, 4);
    clr = 1'b1;
    @(negedge clk); chk("ready_in_clr", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    chk("acc_after_clr", $signed(acc_out), 0);
    push(4, 1'b0);
    send(1, 1);
    repeat (2) @(posedge clk);
    #1 send(1, 1);
    @(posedge clk);
    #1 send(1, 1);
    send(1, 1);
    drain();

    // Asynchronous reset in DRAIN: nothing may be emitted
    repeat (4) send(5, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_acc_out", $signed(acc_out), 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst_ready_after", in_ready, 1);
    repeat (6) @(posedge clk);
    #1 chk("arst_no_result", out_valid, 0);

    // LEN=1 instance
    a1 = 8'hFF;
    b1 = 8'h01;
    in_valid1 = 1'b1;
    @(negedge clk); chk("len1_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("len1_drain_ready", in_ready1, 0);
    chk("len1_k1_valid", out_valid1, 0);
    @(negedge clk); chk("len1_k2_valid", out_valid1, 0);
    @(negedge clk);
    chk("len1_k3_valid", out_valid1, 1);
    chk("len1_acc", $signed(acc_out1), -1);
    chk("len1_ovf", ovf1, 0);
    @(posedge clk); #1;
    chk("len1_ready_after", in_ready1, 1);

    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
